// File: rtl/aib_mac_chk_pkg.sv
// Shared types and constants for the AIB MAC receive pattern checker.
package aib_mac_chk_pkg;

    localparam int SEQ_W           = 32;
    localparam int LOCK_BEATS_DEF  = 4;
    localparam int UNLOCK_ERRS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

endpackage

// File: rtl/aib_mac_rx_chk_if.sv
// Beat input, control and status bundle between the receive FIFO side and the checker.
interface aib_mac_rx_chk_if #(
    parameter int DWIDTH = 40
);
    logic [DWIDTH*8-1:0] data_out_f;
    logic                rx_transfer_en;
    logic                rx_align_done;
    logic                chk_en;
    logic                clr;
    logic                locked;
    logic                err_sticky;
    logic [15:0]         err_cnt;
    logic [31:0]         beat_cnt;
    logic [1:0]          state;

    modport master (
        output data_out_f, rx_transfer_en, rx_align_done, chk_en, clr,
        input  locked, err_sticky, err_cnt, beat_cnt, state
    );

    modport slave (
        input  data_out_f, rx_transfer_en, rx_align_done, chk_en, clr,
        output locked, err_sticky, err_cnt, beat_cnt, state
    );
endinterface

// File: rtl/aib_mac_seq_cmp.sv
// Combinational check of one four-word beat against the incrementing sequence
// and against the expected first-word value.
module aib_mac_seq_cmp
    import aib_mac_chk_pkg::*;
#(
    parameter int DWIDTH = 40
) (
    input  logic [DWIDTH*8-1:0] beat_i,
    input  logic [SEQ_W-1:0]    expected_i,
    output logic                consistent_o,
    output logic                match_o,
    output logic [SEQ_W-1:0]    next_expected_o
);
    localparam int            WW      = 2 * DWIDTH;
    localparam logic [WW-1:0] HI_MASK = ~(WW'({SEQ_W{1'b1}}));

    logic [WW-1:0]    w0_s, w1_s, w2_s, w3_s;
    logic [SEQ_W-1:0] rf0_s;

    // A word is well formed when it holds the given sequence value and nothing above it.
    function automatic logic word_ok(input logic [WW-1:0] w, input logic [SEQ_W-1:0] seq);
        return ((w & HI_MASK) == '0) && (w[SEQ_W-1:0] == seq);
    endfunction

    assign w0_s  = beat_i[0*WW +: WW];
    assign w1_s  = beat_i[1*WW +: WW];
    assign w2_s  = beat_i[2*WW +: WW];
    assign w3_s  = beat_i[3*WW +: WW];
    assign rf0_s = w0_s[SEQ_W-1:0];

    assign consistent_o    = word_ok(w0_s, rf0_s)
                          && word_ok(w1_s, rf0_s + 32'd1)
                          && word_ok(w2_s, rf0_s + 32'd2)
                          && word_ok(w3_s, rf0_s + 32'd3);
    assign match_o         = consistent_o && (rf0_s == expected_i);
    assign next_expected_o = rf0_s + 32'd4;

endmodule

// File: rtl/aib_mac_rx_chk.sv
// Receive-side pattern checker: searches for the incrementing sequence, locks,
// then counts checked and mismatched beats. Status appears two edges after sampling.
module aib_mac_rx_chk
    import aib_mac_chk_pkg::*;
#(
    parameter int DWIDTH      = 40,
    parameter int LOCK_BEATS  = LOCK_BEATS_DEF,
    parameter int UNLOCK_ERRS = UNLOCK_ERRS_DEF
) (
    input  logic             m_rd_clk,
    input  logic             ns_adapter_rstn,
    aib_mac_rx_chk_if.slave  bus
);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_BEATS);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

    logic [DWIDTH*8-1:0] s1_data_q;
    logic                s1_valid_q;
    logic                s1_clr_q;

    chk_state_e       state_q, state_d;
    logic [SEQ_W-1:0] exp_q, exp_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic [15:0]      err_q, err_d;
    logic [31:0]      beat_q, beat_d;
    logic             sticky_q, sticky_d;
    logic [3:0]       good_inc_s;

    logic [1:0]  out_state_q;
    logic        out_locked_q;
    logic        out_sticky_q;
    logic [15:0] out_err_q;
    logic [31:0] out_beat_q;

    logic             cmp_consistent_s;
    logic             cmp_match_s;
    logic [SEQ_W-1:0] cmp_next_s;

    aib_mac_seq_cmp #(.DWIDTH(DWIDTH)) u_cmp (
        .beat_i          (s1_data_q),
        .expected_i      (exp_q),
        .consistent_o    (cmp_consistent_s),
        .match_o         (cmp_match_s),
        .next_expected_o (cmp_next_s)
    );

    // Stage 1: capture the beat with its qualifier; clr travels alongside so it lines up with the beat.
    always_ff @(posedge m_rd_clk or negedge ns_adapter_rstn) begin
        if (!ns_adapter_rstn) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_clr_q   <= 1'b0;
        end else begin
            s1_data_q  <= bus.data_out_f;
            s1_valid_q <= bus.rx_transfer_en && bus.rx_align_done && bus.chk_en;
            s1_clr_q   <= bus.clr;
        end
    end

    // Stage 2: FSM, expected value and counters updated from the compare result.
    always_ff @(posedge m_rd_clk or negedge ns_adapter_rstn) begin
        if (!ns_adapter_rstn) begin
            state_q  <= ST_IDLE;
            exp_q    <= '0;
            good_q   <= 4'd0;
            bad_q    <= 4'd0;
            err_q    <= 16'd0;
            beat_q   <= 32'd0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            sticky_q <= sticky_d;
        end
    end

    // Next-state and counter logic; any unqualified cycle drops back to IDLE with counts held.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        good_d     = good_q;
        bad_d      = bad_q;
        err_d      = err_q;
        beat_d     = beat_q;
        sticky_d   = sticky_q;
        good_inc_s = 4'd0;
        if (!s1_valid_q) begin
            state_d = ST_IDLE;
            good_d  = 4'd0;
            bad_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_SEARCH: begin
                    bad_d = 4'd0;
                    if (!cmp_consistent_s) begin
                        state_d = ST_SEARCH;
                        good_d  = 4'd0;
                    end else begin
                        exp_d = cmp_next_s;
                        // A well-formed beat off the tracked sequence restarts the run from itself.
                        if ((good_q == 4'd0) || cmp_match_s) begin
                            good_inc_s = good_q + 4'd1;
                        end else begin
                            good_inc_s = 4'd1;
                        end
                        if (good_inc_s >= LOCK_N) begin
                            state_d = ST_LOCKED;
                            good_d  = 4'd0;
                        end else begin
                            state_d = ST_SEARCH;
                            good_d  = good_inc_s;
                        end
                    end
                end
                ST_LOCKED: begin
                    exp_d  = cmp_next_s;
                    beat_d = (beat_q == 32'hFFFF_FFFF) ? beat_q : beat_q + 32'd1;
                    if (cmp_match_s) begin
                        bad_d = 4'd0;
                    end else begin
                        err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        sticky_d = 1'b1;
                        if ((bad_q + 4'd1) >= UNLOCK_N) begin
                            state_d = ST_SEARCH;
                            good_d  = 4'd0;
                            bad_d   = 4'd0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = 4'd0;
                    bad_d   = 4'd0;
                end
            endcase
        end
        if (s1_clr_q) begin
            err_d    = 16'd0;
            beat_d   = 32'd0;
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_d;
        end
    end

    // Output register stage so every status port is a flop.
    always_ff @(posedge m_rd_clk or negedge ns_adapter_rstn) begin
        if (!ns_adapter_rstn) begin
            out_state_q  <= 2'd0;
            out_locked_q <= 1'b0;
            out_sticky_q <= 1'b0;
            out_err_q    <= 16'd0;
            out_beat_q   <= 32'd0;
        end else begin
            out_state_q  <= state_q;
            out_locked_q <= (state_q == ST_LOCKED);
            out_sticky_q <= sticky_q;
            out_err_q    <= err_q;
            out_beat_q   <= beat_q;
        end
    end

    assign bus.state      = out_state_q;
    assign bus.locked     = out_locked_q;
    assign bus.err_sticky = out_sticky_q;
    assign bus.err_cnt    = out_err_q;
    assign bus.beat_cnt   = out_beat_q;

endmodule

// File: tb/tb_aib_mac_rx_chk.sv
// Directed bench for aib_mac_rx_chk: lock, single error, unlock/relock, wrap,
// alignment drop, clear-vs-mismatch and asynchronous reset.
module tb_aib_mac_rx_chk;
    localparam int DW = 40;
    localparam int BW = DW * 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    aib_mac_rx_chk_if #(.DWIDTH(DW)) bus ();

    aib_mac_rx_chk #(.DWIDTH(DW), .LOCK_BEATS(4), .UNLOCK_ERRS(8)) dut (
        .m_rd_clk        (clk),
        .ns_adapter_rstn (rst_n),
        .bus             (bus)
    );

    function automatic logic [BW-1:0] mk_beat(input logic [31:0] seq, input logic corrupt);
        logic [BW-1:0] b;
        logic [31:0]   v;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            v = seq + 32'(k);
            if (corrupt && (k == 2)) v = v ^ 32'h0000_0001;
            b[k*2*DW +: 32] = v;
        end
        return b;
    endfunction

    // Each beat is applied at a falling edge; the task returns one falling edge later.
    task automatic drive_beat(input logic [31:0] seq, input logic corrupt, input logic clr_b);
        bus.data_out_f     = mk_beat(seq, corrupt);
        bus.rx_transfer_en = 1'b1;
        bus.rx_align_done  = 1'b1;
        bus.chk_en         = 1'b1;
        bus.clr            = clr_b;
        @(negedge clk);
    endtask

    task automatic drive_idle(input int n);
        bus.rx_transfer_en = 1'b0;
        bus.clr            = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        bus.rx_transfer_en = 1'b0;
        bus.clr            = 1'b1;
        @(negedge clk);
        bus.clr            = 1'b0;
        drive_idle(2);
    endtask

    task automatic lock4(input logic [31:0] start);
        for (int i = 0; i < 4; i++) drive_beat(start + 32'(4*i), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.data_out_f = '0; bus.rx_transfer_en = 1'b0; bus.rx_align_done = 1'b0;
        bus.chk_en = 1'b0; bus.clr = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked got=%0b want=0", bus.locked); end
        n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d want=0", bus.state); end
        n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_sticky got=%0b want=0", bus.err_sticky); end
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.beat_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_beat got=%0d want=0", bus.beat_cnt); end
        rst_n = 1'b1;
        bus.rx_align_done = 1'b1; bus.chk_en = 1'b1;
        drive_idle(2);
    endtask

    // Outputs seen right after beat k+2 is applied reflect beats up to k.
    task automatic test_lock();
        for (int i = 0; i < 5; i++) drive_beat(32'h10 + 32'(4*i), 1'b0, 1'b0);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL lock_early got=%0b want=0", bus.locked); end
        drive_beat(32'h24, 1'b0, 1'b0);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL lock_latency got=%0b want=1", bus.locked); end
        drive_idle(2);
        n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL lock_state got=%0d want=2", bus.state); end
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL lock_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.beat_cnt !== 32'd2) begin n_bad++; $display("FAIL lock_beat got=%0d want=2", bus.beat_cnt); end
        n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL lock_sticky got=%0b want=0", bus.err_sticky); end
    endtask

    task automatic test_single_err();
        do_clr();
        lock4(32'h100);
        drive_beat(32'h110, 1'b1, 1'b0);
        drive_beat(32'h114, 1'b0, 1'b0);
        drive_beat(32'h118, 1'b0, 1'b0);
        drive_idle(2);
        n_cmp++; if (bus.err_cnt !== 16'd1) begin n_bad++; $display("FAIL serr_err got=%0d want=1", bus.err_cnt); end
        n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL serr_sticky got=%0b want=1", bus.err_sticky); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL serr_locked got=%0b want=1", bus.locked); end
        n_cmp++; if (bus.beat_cnt !== 32'd3) begin n_bad++; $display("FAIL serr_beat got=%0d want=3", bus.beat_cnt); end
    endtask

    task automatic test_unlock();
        do_clr();
        lock4(32'h200);
        for (int i = 0; i < 8; i++) drive_beat(32'h210 + 32'(4*i), 1'b1, 1'b0);
        drive_beat(32'h230, 1'b0, 1'b0);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL unl_7_locked got=%0b want=1", bus.locked); end
        n_cmp++; if (bus.err_cnt !== 16'd7) begin n_bad++; $display("FAIL unl_7_err got=%0d want=7", bus.err_cnt); end
        drive_beat(32'h234, 1'b0, 1'b0);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL unl_8_locked got=%0b want=0", bus.locked); end
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL unl_8_state got=%0d want=1", bus.state); end
        n_cmp++; if (bus.err_cnt !== 16'd8) begin n_bad++; $display("FAIL unl_8_err got=%0d want=8", bus.err_cnt); end
        drive_beat(32'h238, 1'b0, 1'b0);
        drive_beat(32'h23C, 1'b0, 1'b0);
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL unl_srch_state got=%0d want=1", bus.state); end
        drive_idle(2);
        n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL relock_state got=%0d want=2", bus.state); end
        n_cmp++; if (bus.err_cnt !== 16'd8) begin n_bad++; $display("FAIL relock_err got=%0d want=8", bus.err_cnt); end
        n_cmp++; if (bus.beat_cnt !== 32'd8) begin n_bad++; $display("FAIL relock_beat got=%0d want=8", bus.beat_cnt); end
    endtask

    task automatic test_wrap();
        do_clr();
        for (int i = 0; i < 7; i++) drive_beat(32'hFFFF_FFEC + 32'(4*i), 1'b0, 1'b0);
        drive_idle(2);
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.beat_cnt !== 32'd3) begin n_bad++; $display("FAIL wrap_beat got=%0d want=3", bus.beat_cnt); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL wrap_locked got=%0b want=1", bus.locked); end
        do_clr();
        for (int i = 0; i < 5; i++) drive_beat(32'hFFFF_FFF2 + 32'(4*i), 1'b0, 1'b0);
        drive_idle(2);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL inwrap_locked got=%0b want=1", bus.locked); end
        n_cmp++; if (bus.beat_cnt !== 32'd1) begin n_bad++; $display("FAIL inwrap_beat got=%0d want=1", bus.beat_cnt); end
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL inwrap_err got=%0d want=0", bus.err_cnt); end
    endtask

    task automatic test_align_drop();
        do_clr();
        lock4(32'h300);
        drive_beat(32'h310, 1'b0, 1'b0);
        drive_beat(32'h314, 1'b0, 1'b0);
        bus.rx_align_done = 1'b0;
        @(negedge clk);
        drive_beat(32'h318, 1'b0, 1'b0);
        drive_beat(32'h31C, 1'b0, 1'b0);
        n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL drop_state got=%0d want=0", bus.state); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL drop_locked got=%0b want=0", bus.locked); end
        n_cmp++; if (bus.beat_cnt !== 32'd2) begin n_bad++; $display("FAIL drop_beat got=%0d want=2", bus.beat_cnt); end
        drive_beat(32'h320, 1'b0, 1'b0);
        drive_beat(32'h324, 1'b0, 1'b0);
        drive_idle(2);
        n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL drop_relock got=%0d want=2", bus.state); end
        n_cmp++; if (bus.beat_cnt !== 32'd2) begin n_bad++; $display("FAIL drop_relock_beat got=%0d want=2", bus.beat_cnt); end
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL drop_err got=%0d want=0", bus.err_cnt); end
    endtask

    task automatic test_clr_and_reset();
        do_clr();
        lock4(32'h400);
        drive_beat(32'h410, 1'b1, 1'b1);
        drive_beat(32'h414, 1'b0, 1'b0);
        drive_idle(2);
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL clrwin_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL clrwin_sticky got=%0b want=0", bus.err_sticky); end
        n_cmp++; if (bus.beat_cnt !== 32'd1) begin n_bad++; $display("FAIL clrwin_beat got=%0d want=1", bus.beat_cnt); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL clrwin_locked got=%0b want=1", bus.locked); end
        drive_idle(2);
        lock4(32'h500);
        drive_beat(32'h510, 1'b1, 1'b0);
        drive_beat(32'h514, 1'b0, 1'b0);
        drive_beat(32'h518, 1'b0, 1'b0);
        drive_beat(32'h51C, 1'b0, 1'b0);
        n_cmp++; if (bus.err_cnt !== 16'd1) begin n_bad++; $display("FAIL prerst_err got=%0d want=1", bus.err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked got=%0b want=0", bus.locked); end
        n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL arst_state got=%0d want=0", bus.state); end
        n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL arst_sticky got=%0b want=0", bus.err_sticky); end
        n_cmp++; if (bus.beat_cnt !== 32'd0) begin n_bad++; $display("FAIL arst_beat got=%0d want=0", bus.beat_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle(2);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_unlock();
        test_wrap();
        test_align_drop();
        test_clr_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
